gf163_digit_mult: RTL and testbench



---
 rtl/gf163_digit_mult.sv | 118 +++++++++++
 tb/tb_gf163_digit_mult.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf163_digit_mult.sv
// Digit-serial GF(2^163) multiplier, f = x^163+x^7+x^6+x^3+1.
// MSB-first digits of b, reduced fully every cycle.
module gf163_digit_mult #(
  parameter int D = 82
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [162:0] a,
  input  logic [162:0] b,
  output logic         busy,
  output logic         done,
  output logic [162:0] c
);

  localparam int M    = 163;
  localparam int NDIG = (M + D - 1) / D;
  localparam int W    = NDIG * D;
  localparam int P    = M + D;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nx;

  logic [M-1:0]  a_reg;
  logic [M-1:0]  acc;
  logic [M-1:0]  acc_nx;
  logic [W-1:0]  b_reg;
  logic [CW-1:0] cnt;
  logic [D-1:0]  digit;
  logic [P-1:0]  ae;
  logic [P-1:0]  pp;
  logic          last;
  logic          accept;

  assign digit  = b_reg[W-1 -: D];
  assign last   = (cnt == CW'(NDIG - 1));
  assign accept = (state == IDLE) && start;
  assign busy   = (state == RUN);

  // Two folds with x^163 = x^7+x^6+x^3+1 clear every bit >= 163
  // for any D up to 163 (excess shrinks D -> D-156 -> none).
  function automatic logic [M-1:0] fold2(
    input logic [P-1:0] v
  );
    logic [P+7:0] t;
    logic [P+7:0] h;
    t = '0;
    t[P-1:0] = v;
    for (int k = 0; k < 2; k++) begin
      h = t >> M;
      t[P+7:M] = '0;
      t = t ^ h ^ (h << 3) ^ (h << 6) ^ (h << 7);
    end
    return t[M-1:0];
  endfunction

  // One digit step: acc*x^D xor a*digit, then reduce.
  always_comb begin
    ae = '0;
    ae[M-1:0] = a_reg;
    pp = '0;
    pp[P-1:D] = acc;
    for (int j = 0; j < D; j++) begin
      if (digit[j]) pp = pp ^ (ae << j);
    end
    acc_nx = fold2(pp);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: leave IDLE on start, return after last digit.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, digit iteration and result/done register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      c     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_reg <= a;
        b_reg <= W'(b);
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nx;
        b_reg <= b_reg << D;
        cnt   <= cnt + CW'(1);
        if (last) begin
          c    <= acc_nx;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf163_digit_mult.sv
// Bench for gf163_digit_mult at D=82 and D=1.
// Scoreboard pushes reference products, popped on done.
module tb_gf163_digit_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         s0, s1;
  logic [162:0] a0, b0, a1, b1;
  logic         busy0, done0, busy1, done1;
  logic [162:0] c0, c1;

  int checks = 0;
  int errors = 0;

  logic [162:0] q0[$];
  logic [162:0] q1[$];

  logic [162:0] x162, x1, one, efold;

  always #5 clk = ~clk;

  gf163_digit_mult #(.D(82)) u0 (
    .clk(clk), .rst_n(rst_n), .start(s0),
    .a(a0), .b(b0),
    .busy(busy0), .done(done0), .c(c0)
  );

  gf163_digit_mult #(.D(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1),
    .a(a1), .b(b1),
    .busy(busy1), .done(done1), .c(c1)
  );

  function automatic logic [162:0] gf_mul(
    input logic [162:0] x,
    input logic [162:0] y
  );
    logic [162:0] r;
    logic cy;
    r = '0;
    for (int i = 162; i >= 0; i--) begin
      cy = r[162];
      r = {r[161:0], 1'b0};
      if (cy) r = r ^ 163'hC9;
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic logic [162:0] rnd();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom()};
    return t[162:0];
  endfunction

  // Scoreboard: every done pops one expected product.
  always @(negedge clk) begin
    logic [162:0] e;
    if (done0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL done0_unexpected c=%h required no done", c0);
      end else begin
        e = q0.pop_front();
        if (c0 !== e) begin
          errors++;
          $display("FAIL sb_d82 c=%h required %h", c0, e);
        end
      end
    end
    if (done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL done1_unexpected c=%h required no done", c1);
      end else begin
        e = q1.pop_front();
        if (c1 !== e) begin
          errors++;
          $display("FAIL sb_d1 c=%h required %h", c1, e);
        end
      end
    end
  end

  // lat = edges from accept edge to done; bc = busy cycles.
  task automatic op(
    input  int           sel,
    input  logic [162:0] x,
    input  logic [162:0] y,
    output int           lat,
    output int           bc,
    output logic [162:0] res
  );
    @(negedge clk);
    if (sel == 0) begin
      a0 = x; b0 = y; s0 = 1'b1;
      q0.push_back(gf_mul(x, y));
    end else begin
      a1 = x; b1 = y; s1 = 1'b1;
      q1.push_back(gf_mul(x, y));
    end
    @(posedge clk);
    #1;
    s0 = 1'b0;
    s1 = 1'b0;
    lat = -1;
    bc = 0;
    res = '0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (sel == 0 ? done0 : done1) begin
        lat = i - 1;
        res = (sel == 0) ? c0 : c1;
        break;
      end
      if (sel == 0 ? busy0 : busy1) bc++;
      @(posedge clk);
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL op_timeout sel=%0d no done in 400 cycles", sel);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s0 = 0; s1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b required 0", busy0);
    end
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b required 0", done0);
    end
    checks++;
    if (c0 !== '0) begin
      errors++;
      $display("FAIL reset_c got %h required 0", c0);
    end
    checks++;
    if ({busy1, done1, c1} !== '0) begin
      errors++;
      $display("FAIL reset_d1 got %b%b %h required 0",
               busy1, done1, c1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unit();
    int lat, bc;
    logic [162:0] r;
    op(0, one, one, lat, bc, r);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL unit_latency got %0d required 2", lat);
    end
    checks++;
    if (bc !== 2) begin
      errors++;
      $display("FAIL unit_busy got %0d required 2", bc);
    end
    checks++;
    if (r !== one) begin
      errors++;
      $display("FAIL unit_c got %h required 1", r);
    end
  endtask

  task automatic test_wrap();
    int lat, bc;
    logic [162:0] r;
    op(0, x162, x1, lat, bc, r);
    checks++;
    if (r !== 163'hC9) begin
      errors++;
      $display("FAIL wrap_c got %h required c9", r);
    end
  endtask

  task automatic test_double_fold();
    int lat, bc;
    logic [162:0] r;
    op(0, x162, x162, lat, bc, r);
    checks++;
    if (r !== efold) begin
      errors++;
      $display("FAIL fold_d82 got %h required %h", r, efold);
    end
    op(1, x162, x162, lat, bc, r);
    checks++;
    if (r !== efold) begin
      errors++;
      $display("FAIL fold_d1 got %h required %h", r, efold);
    end
    checks++;
    if (lat !== 163) begin
      errors++;
      $display("FAIL fold_d1_latency got %0d required 163", lat);
    end
    checks++;
    if (bc !== 163) begin
      errors++;
      $display("FAIL fold_d1_busy got %0d required 163", bc);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [162:0] x, y, r1, r2;
    x = rnd();
    y = rnd();
    op(0, x, y, lat, bc, r1);
    op(0, y, x, lat, bc, r2);
    checks++;
    if (r1 !== r2) begin
      errors++;
      $display("FAIL commute ab=%h ba=%h", r1, r2);
    end
    for (int i = 0; i < 40; i++) begin
      op(0, rnd(), rnd(), lat, bc, r1);
    end
    for (int i = 0; i < 4; i++) begin
      op(1, rnd(), rnd(), lat, bc, r1);
    end
  endtask

  task automatic test_busy_ignore();
    logic [162:0] x, y;
    int nd, extra;
    x = rnd();
    y = rnd();
    nd = 0;
    extra = 0;
    @(negedge clk);
    a0 = x; b0 = y; s0 = 1'b1;
    q0.push_back(gf_mul(x, y));
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0) begin
        s0 = 1'b0;
        nd++;
        break;
      end
      if (busy0) begin
        s0 = 1'b1;
        a0 = rnd();
        b0 = rnd();
      end
      @(posedge clk);
    end
    s0 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done0 || busy0) extra++;
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL busy_ign_done got %0d required 1", nd);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_ign_extra got %0d required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [162:0] x, y;
    int lat;
    lat = -1;
    x = rnd();
    y = rnd();
    @(negedge clk);
    a0 = x; b0 = y; s0 = 1'b1;
    q0.push_back(gf_mul(x, y));
    @(posedge clk);
    #1;
    s0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0) break;
      @(posedge clk);
    end
    x = rnd();
    y = rnd();
    a0 = x; b0 = y; s0 = 1'b1;
    q0.push_back(gf_mul(x, y));
    @(posedge clk);
    #1;
    s0 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done0) begin
        lat = i - 1;
        break;
      end
      @(posedge clk);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL b2b_latency got %0d required 2", lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic [162:0] r;
    @(negedge clk);
    a0 = rnd(); b0 = rnd(); s0 = 1'b1;
    @(posedge clk);
    #1;
    s0 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_flags got %b%b required 00",
               busy0, done0);
    end
    checks++;
    if (c0 !== '0) begin
      errors++;
      $display("FAIL rmid_c got %h required 0", c0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(0, x162, x1, lat, bc, r);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL rmid_latency got %0d required 2", lat);
    end
    checks++;
    if (r !== 163'hC9) begin
      errors++;
      $display("FAIL rmid_c_after got %h required c9", r);
    end
  endtask

  initial begin
    one = '0;
    one[0] = 1'b1;
    x1 = '0;
    x1[1] = 1'b1;
    x162 = '0;
    x162[162] = 1'b1;
    efold = '0;
    efold[161] = 1'b1;
    efold[12] = 1'b1;
    efold[10] = 1'b1;
    efold[5] = 1'b1;
    efold[1] = 1'b1;
    test_reset();
    test_unit();
    test_wrap();
    test_double_fold();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left %0d/%0d required 0/0",
               q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
